mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// fixed read latency of MEM_LAT cycles.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] adr0,
    input  logic [31:0] adr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        busy,
    output logic        gnt
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [DW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          mem_we_q, mem_we_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          busy_q, busy_d;
    logic          sel;
    logic          sel_we;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wd_q     <= '0;
            mem_we_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            mem_we_q <= mem_we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and registered-output logic; write ack and mem_we are set on
    // the grant edge so they appear during the ISSUE cycle itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wd_d     = wd_q;
        mem_we_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        sel      = (req0 && req1) ? ~last_q : req1;
        sel_we   = sel ? we1 : we0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d  = S_ISSUE;
                    gnt_d    = sel;
                    last_d   = sel;
                    we_d     = sel_we;
                    adr_d    = sel ? adr1 : adr0;
                    wd_d     = sel ? wd1 : wd0;
                    mem_we_d = sel_we;
                    ack0_d   = sel_we && !sel;
                    ack1_d   = sel_we && sel;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                    if (gnt_q) begin
                        rd1_d = mem_rd;
                    end else begin
                        rd0_d = mem_rd;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign rd0     = rd0_q;
    assign rd1     = rd1_q;
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    assign mem_we  = mem_we_q;
    assign busy    = busy_q;
    assign gnt     = gnt_q;

endmodule
